// File: rtl/antiglitch_filter_core.sv
// Per-channel glitch filter: synchronizes raw pins, accepts a new level only after it has been
// stable for the threshold, and counts rejected glitches per channel.
module antiglitch_filter_core #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned GCNT_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned SelW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_enable,
    input  logic [CNT_WIDTH-1:0]  cfg_threshold,
    input  logic                  cfg_clear,
    input  logic [NUM_CH-1:0]     din,
    output logic [NUM_CH-1:0]     dout,
    output logic [NUM_CH-1:0]     edge_rise,
    output logic [NUM_CH-1:0]     edge_fall,
    input  logic [SelW-1:0]       gcnt_sel,
    output logic [GCNT_WIDTH-1:0] glitch_cnt,
    output logic                  glitch_any
);

    typedef enum logic {StStable, StPending} st_e;

    logic [NUM_CH-1:0]     sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]     s;
    logic [CNT_WIDTH-1:0]  teff;

    st_e                   st_q   [NUM_CH];
    st_e                   st_d   [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnt_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnt_d  [NUM_CH];
    logic [GCNT_WIDTH-1:0] gcnt_q [NUM_CH];
    logic [GCNT_WIDTH-1:0] gcnt_d [NUM_CH];
    logic [NUM_CH-1:0]     dout_q, dout_d;
    logic [NUM_CH-1:0]     rise_q, rise_d;
    logic [NUM_CH-1:0]     fall_q, fall_d;
    logic [GCNT_WIDTH-1:0] glitch_cnt_q, glitch_cnt_d;
    logic                  any_q, any_d;

    function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [GCNT_WIDTH-1:0] gcnt_sat_inc(input logic [GCNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + GCNT_WIDTH'(1);
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign teff = (cfg_threshold == '0) ? CNT_WIDTH'(1) : cfg_threshold;

    // The count includes the current differing cycle, so a level seen for Teff synced cycles
    // is accepted on the Teff-th of them.
    always_comb begin
        dout_d = dout_q;
        any_d  = any_q;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];
            gcnt_d[i] = gcnt_q[i];
            if (!cfg_enable) begin
                st_d[i]   = StStable;
                cnt_d[i]  = '0;
                dout_d[i] = s[i];
            end else if (s[i] != dout_q[i]) begin
                if (((st_q[i] == StStable) ? CNT_WIDTH'(1) : cnt_sat_inc(cnt_q[i])) >= teff) begin
                    st_d[i]   = StStable;
                    cnt_d[i]  = '0;
                    dout_d[i] = s[i];
                end else begin
                    st_d[i]  = StPending;
                    cnt_d[i] = (st_q[i] == StStable) ? CNT_WIDTH'(1) : cnt_sat_inc(cnt_q[i]);
                end
            end else begin
                if (st_q[i] == StPending) begin
                    gcnt_d[i] = gcnt_sat_inc(gcnt_q[i]);
                    any_d     = 1'b1;
                end
                st_d[i]  = StStable;
                cnt_d[i] = '0;
            end
        end
        if (cfg_clear) begin
            for (int i = 0; i < NUM_CH; i++) gcnt_d[i] = '0;
            any_d = 1'b0;
        end
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    always_comb begin
        glitch_cnt_d = '0;
        if (32'(gcnt_sel) < NUM_CH) glitch_cnt_d = gcnt_q[gcnt_sel];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= StStable;
                cnt_q[i]  <= '0;
                gcnt_q[i] <= '0;
            end
            dout_q       <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            glitch_cnt_q <= '0;
            any_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                gcnt_q[i] <= gcnt_d[i];
            end
            dout_q       <= dout_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            glitch_cnt_q <= glitch_cnt_d;
            any_q        <= any_d;
        end
    end

    assign dout       = dout_q;
    assign edge_rise  = rise_q;
    assign edge_fall  = fall_q;
    assign glitch_cnt = glitch_cnt_q;
    assign glitch_any = any_q;

endmodule
